// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: TX/RX FIFO burst sequencer in front of a single-byte SPI master.
// Optional WAIT_DONE watchdog is built when SPI_BURST_TIMEOUT_EN is defined.
module spi_burst_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic                        go,
  input  logic [7:0]                  burst_len,
  output logic                        busy,
  output logic                        burst_done,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic [7:0]                  spi_din,
  output logic                        spi_start,
  input  logic                        spi_ready,
  input  logic                        spi_done_tick,
  input  logic [7:0]                  spi_dout,
  output logic                        timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [AW:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, flush_s, timeout_hit_s;
  logic        busy_q, burst_done_q, spi_start_q;
  logic [7:0]  spi_din_q;

  assign tx_full_s  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign tx_empty_s = (tx_wr_q == tx_rd_q);
  assign rx_full_s  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_empty_s = (rx_wr_q == rx_rd_q);
  assign tx_push_s  = tx_valid && !tx_full_s;
  assign rx_pop_s   = !rx_empty_s && rx_ready;

  assign tx_ready   = !tx_full_s;
  assign tx_level   = tx_wr_q - tx_rd_q;
  assign rx_level   = rx_wr_q - rx_rd_q;
  assign rx_valid   = !rx_empty_s;
  assign rx_data    = rx_empty_s ? 8'h00 : rx_mem_q[rx_rd_q[AW-1:0]];
  assign busy       = busy_q;
  assign burst_done = burst_done_q;
  assign spi_start  = spi_start_q;
  assign spi_din    = spi_din_q;

  // Burst sequencing: issue only when a byte, the master and an RX slot are all available.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tx_pop_s    = 1'b0;
    rx_push_s   = 1'b0;
    flush_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (burst_len != 8'd0) begin
            remaining_d = burst_len;
            state_d     = S_ISSUE;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (spi_ready && !tx_empty_s && !rx_full_s) begin
          tx_pop_s = 1'b1;
          state_d  = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (spi_done_tick) begin
          rx_push_s   = 1'b1;
          remaining_d = remaining_q - 8'd1;
          state_d     = (remaining_q == 8'd1) ? S_FINISH : S_ISSUE;
        end else if (timeout_hit_s) begin
          flush_s = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state and registered master/host handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= 8'd0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      spi_start_q  <= 1'b0;
      spi_din_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      busy_q       <= (state_d == S_ISSUE) || (state_d == S_WAIT);
      burst_done_q <= (state_d == S_FINISH);
      spi_start_q  <= tx_pop_s;
      if (tx_pop_s) begin
        spi_din_q <= tx_mem_q[tx_rd_q[AW-1:0]];
      end
    end
  end

  // FIFO pointers; a flush also discards a byte pushed in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (tx_push_s) tx_wr_q <= tx_wr_q + (AW+1)'(1);
      if (flush_s) tx_rd_q <= tx_push_s ? tx_wr_q + (AW+1)'(1) : tx_wr_q;
      else if (tx_pop_s) tx_rd_q <= tx_rd_q + (AW+1)'(1);
      if (rx_push_s) rx_wr_q <= rx_wr_q + (AW+1)'(1);
      if (rx_pop_s) rx_rd_q <= rx_rd_q + (AW+1)'(1);
    end
  end

  // FIFO storage needs no reset; reads are qualified by the pointer state.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_q[tx_wr_q[AW-1:0]] <= tx_data;
    if (rx_push_s) rx_mem_q[rx_wr_q[AW-1:0]] <= spi_dout;
  end

`ifdef SPI_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_err_q;

  assign timeout_hit_s = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err   = timeout_err_q;

  // Watchdog counts idle cycles in WAIT_DONE; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if ((state_q == S_WAIT) && !spi_done_tick) begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
        if (timeout_hit_s) timeout_err_q <= 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: stub SPI master plus queue-based model of bytes sent/received.
module tb_spi_burst_ctrl;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          go = 1'b0;
  logic [7:0]    burst_len = 8'h00;
  logic          busy, burst_done, spi_start, timeout_err;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    spi_din;
  logic          spi_ready = 1'b1;
  logic          spi_done_tick = 1'b0;
  logic [7:0]    spi_dout = 8'h00;

  spi_burst_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .go(go), .burst_len(burst_len),
    .busy(busy), .burst_done(burst_done), .tx_level(tx_level), .rx_level(rx_level),
    .spi_din(spi_din), .spi_start(spi_start), .spi_ready(spi_ready),
    .spi_done_tick(spi_done_tick), .spi_dout(spi_dout), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Stub master state (written only by the stub process)
  int         cyc = 0, n_starts = 0, n_done = 0, done_cnt = 0, lat_cnt = 0;
  bit         active = 1'b0;
  logic [7:0] obs_din [256];
  int         start_cyc [256];
  int         done_cyc [256];
  // Written only by the stimulus process
  int         master_lat = 20;
  bit         master_dead = 1'b0;
  logic [7:0] resp_src [256];

  // Stub single-byte master: answers each start after master_lat cycles with resp_src bytes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (burst_done) done_cnt <= done_cnt + 1;
    if (spi_done_tick) done_cyc[8'(n_done - 1)] <= cyc;
    spi_done_tick <= 1'b0;
    if (!rst) begin
      spi_ready <= 1'b1;
      active    <= 1'b0;
    end else if (spi_start && !master_dead) begin
      obs_din[8'(n_starts)]   <= spi_din;
      start_cyc[8'(n_starts)] <= cyc;
      n_starts  <= n_starts + 1;
      spi_ready <= 1'b0;
      active    <= 1'b1;
      lat_cnt   <= master_lat;
    end else if (active) begin
      if (lat_cnt <= 1) begin
        spi_done_tick <= 1'b1;
        spi_dout      <= resp_src[8'(n_done)];
        n_done        <= n_done + 1;
        spi_ready     <= 1'b1;
        active        <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  int         checks = 0, errors = 0;
  logic [7:0] exp_tx [$];
  int         pushed = 0, tx_base = 0, obs_rd = 0, rx_rd = 0, go_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_occ();
    return pushed - (n_starts - tx_base);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_ready"},  32'(tx_ready),    32'(1));
    check({tag, "_rx_valid"},  32'(rx_valid),    32'(0));
    check({tag, "_rx_data"},   32'(rx_data),     32'(0));
    check({tag, "_busy"},      32'(busy),        32'(0));
    check({tag, "_done"},      32'(burst_done),  32'(0));
    check({tag, "_start"},     32'(spi_start),   32'(0));
    check({tag, "_din"},       32'(spi_din),     32'(0));
    check({tag, "_tx_level"},  32'(tx_level),    32'(0));
    check({tag, "_rx_level"},  32'(rx_level),    32'(0));
    check({tag, "_tmo_err"},   32'(timeout_err), 32'(0));
  endtask

  task automatic push(input logic [7:0] b);
    bit acc;
    @(negedge clk);
    acc = (model_occ() < DEPTH);
    tx_data = b; tx_valid = 1'b1;
    check("tx_ready", 32'(tx_ready), 32'(acc));
    if (acc) begin exp_tx.push_back(b); pushed++; end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic do_go(input int len);
    @(negedge clk);
    go = 1'b1; burst_len = 8'(len); go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", 32'(busy), 32'(len != 0));
    check("done_after_go", 32'(burst_done), 32'(len == 0));
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int t = 0; t < budget && done_cnt == d0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_tx(input string tag);
    while (obs_rd < n_starts) begin
      if (exp_tx.size() == 0) begin
        check({tag, "_start_count"}, 32'(n_starts), 32'(obs_rd));
        obs_rd = n_starts;
      end else begin
        check({tag, "_spi_din"}, 32'(obs_din[8'(obs_rd)]), 32'(exp_tx.pop_front()));
        obs_rd++;
      end
    end
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'(1));
    check({tag, "_rx_data"},  32'(rx_data),  32'(resp_src[8'(rx_rd)]));
    rx_ready = 1'b1; rx_rd++;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drain_rx(input string tag);
    @(negedge clk);
    check({tag, "_rx_level"}, 32'(rx_level), 32'(n_done - rx_rd));
    while (rx_rd < n_done) pop_check(tag);
    @(negedge clk);
    check({tag, "_rx_empty"}, 32'(rx_valid), 32'(0));
  endtask

  task automatic burst(input string tag, input int len, input int budget);
    int d0, s0;
    d0 = done_cnt; s0 = n_starts;
    do_go(len);
    wait_done(d0, budget);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(1));
    check({tag, "_starts"},      32'(n_starts - s0), 32'(len));
    check({tag, "_busy_end"},    32'(busy),          32'(0));
    check_tx(tag);
  endtask

  task automatic rebase();
    exp_tx.delete();
    pushed = 0; tx_base = n_starts; obs_rd = n_starts; rx_rd = n_done;
  endtask

  initial begin
    int d0, s0, r0, k, n, len;
    for (int i = 0; i < 256; i++) resp_src[i] = 8'($urandom);
    resp_src[0] = 8'h3C; resp_src[1] = 8'hAA; resp_src[2] = 8'h01;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Basic burst with fixed bytes and 20-cycle master latency
    push(8'hA5); push(8'h55); push(8'hFF);
    check("basic_tx_level", 32'(tx_level), 32'(3));
    s0 = n_starts; r0 = n_done;
    burst("basic", 3, 300);
    check("basic_go_to_start", 32'(start_cyc[8'(s0)]), 32'(go_cyc + 2));
    check("basic_tick_to_start", 32'(start_cyc[8'(s0 + 1)]), 32'(done_cyc[8'(r0)] + 2));
    drain_rx("basic");

    // Underrun: one byte queued for a two-byte burst
    master_lat = 6;
    push(8'($urandom));
    d0 = done_cnt; s0 = n_starts;
    do_go(2);
    for (int t = 0; t < 100 && n_starts == s0; t++) @(negedge clk);
    repeat (50) @(negedge clk);
    check("underrun_busy", 32'(busy), 32'(1));
    check("underrun_starts", 32'(n_starts - s0), 32'(1));
    check("underrun_no_done", 32'(done_cnt - d0), 32'(0));
    push(8'h12);
    wait_done(d0, 100);
    check("underrun_starts2", 32'(n_starts - s0), 32'(2));
    check("underrun_done", 32'(done_cnt - d0), 32'(1));
    check_tx("underrun");
    drain_rx("underrun");

    // RX backpressure: 10-byte burst with the host not popping
    master_lat = 5;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    d0 = done_cnt; s0 = n_starts; r0 = n_done;
    do_go(10);
    for (int t = 0; t < 100 && n_starts < s0 + 2; t++) @(negedge clk);
    push(8'($urandom)); push(8'($urandom));
    for (int t = 0; t < 400 && n_done < r0 + 8; t++) @(negedge clk);
    repeat (40) @(negedge clk);
    check("bp_starts", 32'(n_starts - s0), 32'(8));
    check("bp_rx_level", 32'(rx_level), 32'(DEPTH));
    check("bp_busy", 32'(busy), 32'(1));
    check("bp_tx_level", 32'(tx_level), 32'(2));
    pop_check("bp"); pop_check("bp");
    wait_done(d0, 200);
    check("bp_starts_total", 32'(n_starts - s0), 32'(10));
    check("bp_done", 32'(done_cnt - d0), 32'(1));
    check_tx("bp");
    drain_rx("bp");

    // Zero-length burst
    burst("len0", 0, 20);

    // go while busy is ignored
    d0 = done_cnt; s0 = n_starts;
    do_go(1);
    repeat (3) @(negedge clk);
    @(negedge clk); go = 1'b1; burst_len = 8'd5;
    @(negedge clk); go = 1'b0;
    push(8'($urandom));
    wait_done(d0, 100);
    repeat (20) @(negedge clk);
    check("gobusy_done", 32'(done_cnt - d0), 32'(1));
    check("gobusy_starts", 32'(n_starts - s0), 32'(1));
    check("gobusy_idle", 32'(busy), 32'(0));
    check_tx("gobusy");
    drain_rx("gobusy");

    // TX full: ninth push dropped
    for (int i = 0; i < 9; i++) push(8'($urandom));
    check("full_tx_level", 32'(tx_level), 32'(DEPTH));
    master_lat = 3;
    burst("full_drain", 8, 300);
    drain_rx("full_drain");

    // Randomised bursts against the byte-queue model
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      if (n > DEPTH - model_occ()) n = DEPTH - model_occ();
      for (int i = 0; i < n; i++) push(8'($urandom));
      len = $urandom_range(1, model_occ());
      master_lat = $urandom_range(1, 12);
      burst("rand", len, 400);
      check("rand_tx_level", 32'(tx_level), 32'(model_occ()));
      drain_rx("rand");
    end

    // Reset mid-burst
    master_lat = 10;
    push(8'h01); push(8'h02); push(8'h03);
    s0 = n_starts;
    do_go(3);
    for (int t = 0; t < 100 && n_starts == s0; t++) @(negedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rebase();
    check_reset_vals("post_reset");

`ifdef SPI_BURST_TIMEOUT_EN
    master_dead = 1'b1;
    push(8'h44); push(8'h55);
    do_go(2);
    k = go_cyc;
    while (cyc < k + 65) @(negedge clk);
    check("tmo_not_yet", 32'(timeout_err), 32'(0));
    check("tmo_tx_pending", 32'(tx_level), 32'(1));
    @(negedge clk);
    check("tmo_err", 32'(timeout_err), 32'(1));
    check("tmo_done", 32'(burst_done), 32'(1));
    check("tmo_busy", 32'(busy), 32'(0));
    check("tmo_flushed", 32'(tx_level), 32'(0));
    repeat (5) @(negedge clk);
    check("tmo_sticky", 32'(timeout_err), 32'(1));
`else
    k = 0;
    check("tmo_tied_off", 32'(timeout_err), 32'(k));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
